// File: rtl/frame_write_packer.sv
// -----------------------------------------------------------------------------
// frame_write_packer
//
// Streaming write stage in front of an SRAM arbiter write port. Takes 24-bit
// RGB pixels, reduces each to RGB332 and packs four of them into one 32-bit
// SRAM word. Each finished word is issued as a {mask, addr, data} write
// command addressed into the selected frame buffer. Frame start and
// completion use four-phase start/start_ack and done/done_ack handshakes.
//
// Ports:
//   clock, reset_n      rising-edge clock, asynchronous active-low reset
//   start / start_ack   frame request from swap controller / acknowledge
//   done / done_ack     frame complete / acknowledge from swap controller
//   buf_sel             target buffer (0 -> BASE0, 1 -> BASE1), sampled at start
//   pix, pix_valid,     pixel input {R,G,B}, ready/valid
//   pix_ready
//   dout, valid, ready  write command {mask[3:0], addr[17:0], data[31:0]}
//
// Optional feature macro: PACKER_CHROMAKEY_EN
//   When defined, pixel 24'hFF00FF is transparent: its byte-enable is cleared,
//   and a word whose mask ends up all-zero is not emitted at all (its address
//   slot is still consumed).
// -----------------------------------------------------------------------------
module frame_write_packer #(
   parameter int unsigned N_PIXEL = 480000,
   parameter logic [17:0] BASE0   = 18'h00000,
   parameter logic [17:0] BASE1   = 18'h20000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        start_ack,
   output logic        done,
   input  logic        done_ack,
   input  logic        buf_sel,
   input  logic [23:0] pix,
   input  logic        pix_valid,
   output logic        pix_ready,
   output logic [53:0] dout,
   output logic        valid,
   input  logic        ready
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START_ACK = 3'd1,
      S_RUN       = 3'd2,
      S_DRAIN     = 3'd3,
      S_DONE      = 3'd4,
      S_DONE_WAIT = 3'd5
   } state_t;

   localparam logic [19:0] LAST_PIX = 20'(N_PIXEL - 1);

   state_t      state_r;
   state_t      state_s;
   logic [17:0] base_r;
   logic [19:0] pix_cnt_r;
   logic [17:0] word_cnt_r;
   logic [31:0] acc_data_r;
   logic [3:0]  acc_mask_r;
   logic        valid_r;
   logic [53:0] dout_r;
   logic        start_ack_r;
   logic        done_r;

   logic [1:0]  lane_s;
   logic        last_s;
   logic        word_end_s;
   logic        pix_ready_s;
   logic        accept_s;
   logic [7:0]  byte_s;
   logic        transparent_s;
   logic [31:0] lane_data_s;
   logic [3:0]  lane_mask_s;
   logic [31:0] word_data_s;
   logic [3:0]  word_mask_s;
   logic        load_s;
   logic        frame_init_s;

   // Pixel decode: RGB332 reduction and (optionally) chroma-key detection.
   assign byte_s = {pix[23:21], pix[15:13], pix[7:6]};
`ifdef PACKER_CHROMAKEY_EN
   assign transparent_s = (pix == 24'hFF00FF);
`else
   // The low colour bits only matter for the key compare; keep them visibly consumed.
   logic unused_pix_s;
   assign unused_pix_s  = ^{pix[20:16], pix[12:8], pix[5:0]};
   assign transparent_s = 1'b0;
`endif

   // Lane tracking: lanes align with pix_cnt because every word starts at a multiple of 4.
   assign lane_s     = pix_cnt_r[1:0];
   assign last_s     = (pix_cnt_r == LAST_PIX);
   assign word_end_s = (lane_s == 2'd3) | last_s;

   // A word-completing pixel may only enter when the output register is free or draining now.
   assign pix_ready_s  = (state_r == S_RUN) & (~word_end_s | ~valid_r | ready);
   assign accept_s     = pix_valid & pix_ready_s;
   assign frame_init_s = (state_r == S_IDLE) & start;

   // Place the current byte into its lane and merge with the bytes already collected.
   always_comb begin
      lane_data_s = 32'h0000_0000;
      lane_mask_s = 4'b0000;
      case (lane_s)
         2'd0: begin lane_data_s = {24'h000000, byte_s};          lane_mask_s = 4'b0001; end
         2'd1: begin lane_data_s = {16'h0000, byte_s, 8'h00};     lane_mask_s = 4'b0010; end
         2'd2: begin lane_data_s = {8'h00, byte_s, 16'h0000};     lane_mask_s = 4'b0100; end
         2'd3: begin lane_data_s = {byte_s, 24'h000000};          lane_mask_s = 4'b1000; end
         default: begin lane_data_s = 32'h0000_0000;              lane_mask_s = 4'b0000; end
      endcase
      if (transparent_s) begin
         word_data_s = acc_data_r;
         word_mask_s = acc_mask_r;
      end else begin
         word_data_s = acc_data_r | lane_data_s;
         word_mask_s = acc_mask_r | lane_mask_s;
      end
   end

   // A fully transparent word is skipped but still consumes its address slot.
   assign load_s = accept_s & word_end_s & (word_mask_s != 4'b0000);

   // Next-state logic for the frame handshake / run / drain sequence.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start) state_s = S_START_ACK;
            else       state_s = S_IDLE;
         end
         S_START_ACK: begin
            if (!start) state_s = S_RUN;
            else        state_s = S_START_ACK;
         end
         S_RUN: begin
            if (accept_s && last_s) state_s = S_DRAIN;
            else                    state_s = S_RUN;
         end
         S_DRAIN: begin
            // Done may be raised on the same edge the last word is taken.
            if (!valid_r || ready) state_s = S_DONE;
            else                   state_s = S_DRAIN;
         end
         S_DONE: begin
            if (done_ack) state_s = S_DONE_WAIT;
            else          state_s = S_DONE;
         end
         S_DONE_WAIT: begin
            if (!done_ack) state_s = S_IDLE;
            else           state_s = S_DONE_WAIT;
         end
         default: state_s = S_IDLE;
      endcase
   end

   // State register and registered handshake outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= S_IDLE;
         start_ack_r <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         start_ack_r <= (state_s == S_START_ACK);
         done_r      <= (state_s == S_DONE);
      end
   end

   // Frame counters and the partial-word accumulator.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         base_r     <= 18'h00000;
         pix_cnt_r  <= 20'd0;
         word_cnt_r <= 18'd0;
         acc_data_r <= 32'h0000_0000;
         acc_mask_r <= 4'b0000;
      end else if (frame_init_s) begin
         base_r     <= buf_sel ? BASE1 : BASE0;
         pix_cnt_r  <= 20'd0;
         word_cnt_r <= 18'd0;
         acc_data_r <= 32'h0000_0000;
         acc_mask_r <= 4'b0000;
      end else if (accept_s) begin
         pix_cnt_r <= pix_cnt_r + 20'd1;
         if (word_end_s) begin
            word_cnt_r <= word_cnt_r + 18'd1;
            acc_data_r <= 32'h0000_0000;
            acc_mask_r <= 4'b0000;
         end else begin
            acc_data_r <= word_data_s;
            acc_mask_r <= word_mask_s;
         end
      end
   end

   // Single-entry output register; load and consume may coincide without a bubble.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_r <= 1'b0;
         dout_r  <= 54'd0;
      end else if (load_s) begin
         valid_r <= 1'b1;
         dout_r  <= {word_mask_s, base_r + word_cnt_r, word_data_s};
      end else if (ready) begin
         valid_r <= 1'b0;
      end
   end

   assign start_ack = start_ack_r;
   assign done      = done_r;
   assign pix_ready = pix_ready_s;
   assign valid     = valid_r;
   assign dout      = dout_r;

endmodule

// File: tb/tb_frame_write_packer.sv
// -----------------------------------------------------------------------------
// tb_frame_write_packer
//
// Self-checking bench for frame_write_packer with a 10-pixel frame, so the
// last word of every frame is partial (two lanes). The reference model builds
// the expected write list for each frame directly from the pixel array with
// integer arithmetic, and a small occupancy model predicts valid / pix_ready.
// Inputs are driven on the falling edge, outputs are checked 1 time unit later.
// -----------------------------------------------------------------------------
module tb_frame_write_packer;

   localparam int unsigned N  = 10;
   localparam logic [17:0] B0 = 18'h00000;
   localparam logic [17:0] B1 = 18'h20000;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        start_ack;
   logic        done;
   logic        done_ack = 1'b0;
   logic        buf_sel = 1'b0;
   logic [23:0] pix = 24'h0;
   logic        pix_valid = 1'b0;
   logic        pix_ready;
   logic [53:0] dout;
   logic        valid;
   logic        ready = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [23:0] pix_mem [N];
   logic [3:0]  word_mask [N];
   logic [53:0] exp_q [$];
   logic [23:0] pat [4];

   frame_write_packer #(.N_PIXEL(N), .BASE0(B0), .BASE1(B1)) dut (
      .clock(clock), .reset_n(reset_n),
      .start(start), .start_ack(start_ack),
      .done(done), .done_ack(done_ack),
      .buf_sel(buf_sel),
      .pix(pix), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .dout(dout), .valid(valid), .ready(ready)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic bit is_key(input logic [23:0] p);
`ifdef PACKER_CHROMAKEY_EN
      return (p == 24'hFF00FF);
`else
      return (p == 24'hFF00FF) && 1'b0;
`endif
   endfunction

   // Expected writes for the frame held in pix_mem.
   task automatic build_model(input logic bsel);
      int r, g, b, by, lane;
      logic [31:0] d;
      logic [3:0]  m;
      logic [17:0] base;
      base = bsel ? B1 : B0;
      exp_q.delete();
      d = 32'h0;
      m = 4'h0;
      for (int i = 0; i < int'(N); i++) begin
         lane = i % 4;
         r  = int'(pix_mem[i][23:16]);
         g  = int'(pix_mem[i][15:8]);
         b  = int'(pix_mem[i][7:0]);
         by = (r / 32) * 32 + (g / 32) * 4 + (b / 64);
         if (!is_key(pix_mem[i])) begin
            d = d | (32'(by) << (8 * lane));
            m = m | (4'b0001 << lane);
         end
         if (lane == 3 || i == int'(N) - 1) begin
            word_mask[i / 4] = m;
            if (m != 4'b0000) exp_q.push_back({m, 18'(base + 18'(i / 4)), d});
            d = 32'h0;
            m = 4'h0;
         end
      end
   endtask

   task automatic do_start(input logic bsel);
      @(negedge clock);
      start = 1'b1;
      buf_sel = bsel;
      #1 chk("start_ack_idle", 64'(start_ack), 64'd0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         #1 chk("start_ack_high", 64'(start_ack), 64'd1);
      end
      @(negedge clock);
      start = 1'b0;
      buf_sel = ~bsel;
   endtask

   // mode 0: full rate, fixed pattern; 1: random; 2: 10-cycle backpressure; 3: chroma-key pattern
   task automatic run_frame(input logic bsel, input int mode, input int abort_at);
      int sent, cyc;
      bit occ, occ_n, prev_stall, exp_new, completes, exp_pr, acc;
      logic [53:0] prev_dout, new_word;
      for (int i = 0; i < int'(N); i++) begin
         if (mode == 0 || mode == 2) pix_mem[i] = pat[i % 4];
         else if (mode == 3)          pix_mem[i] = (i < 8 && i != 1) ? 24'hFF00FF : pat[i % 4];
         else                         pix_mem[i] = 24'($urandom);
      end
      build_model(bsel);
      do_start(bsel);
      sent = 0; cyc = 0; occ = 0; prev_stall = 0; exp_new = 0;
      prev_dout = '0; new_word = '0;
      while ((sent < int'(N) || occ) && cyc < 400) begin
         @(negedge clock);
         pix_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : (sent < int'(N));
         pix = (sent < int'(N)) ? pix_mem[sent] : 24'($urandom);
         if (mode == 1)      ready = ($urandom_range(0, 3) != 0);
         else if (mode == 2) ready = !(cyc >= 6 && cyc < 16);
         else                ready = 1'b1;
         if (mode == 1) start = 1'($urandom_range(0, 1));
         #1;
         completes = (sent % 4 == 3) || (sent == int'(N) - 1);
         exp_pr = (sent < int'(N)) && (!completes || !occ || ready);
         chk("start_ack_run", 64'(start_ack), 64'd0);
         chk("done_early", 64'(done), 64'd0);
         chk("valid", 64'(valid), 64'(occ));
         chk("pix_ready", 64'(pix_ready), 64'(exp_pr));
         if (exp_new)    chk("word_latency", 64'(dout), 64'(new_word));
         if (prev_stall) chk("dout_stable", 64'(dout), 64'(prev_dout));
         if (occ && ready) begin
            if (exp_q.size() == 0) chk("extra_write", 64'(dout), 64'd0 - 64'd1);
            else begin
               chk("write", 64'(dout), 64'(exp_q[0]));
               void'(exp_q.pop_front());
            end
         end
         acc = pix_valid && exp_pr;
         exp_new = 0;
         occ_n = occ && !ready;
         if (acc && completes && word_mask[sent / 4] != 4'b0000) begin
            occ_n = 1;
            exp_new = 1;
            new_word = (exp_q.size() > 0) ? exp_q[0] : '0;
         end
         prev_stall = occ && !ready;
         prev_dout = dout;
         occ = occ_n;
         if (acc) sent++;
         cyc++;
         if (abort_at > 0 && sent >= abort_at) begin
            reset_n = 1'b0;
            start = 1'b0;
            #1 chk("reset_mid_frame", 64'({start_ack, done, pix_ready, valid, dout}), 64'd0);
            pix_valid = 1'b0;
            @(negedge clock);
            reset_n = 1'b1;
            return;
         end
      end
      pix_valid = 1'b0;
      start = 1'b0;
      if (cyc >= 400) chk("frame_timeout", 64'(cyc), 64'd0);
   endtask

   task automatic done_hs();
      int k;
      k = 0;
      while (done !== 1'b1 && k < 20) begin
         @(negedge clock);
         #1 k++;
      end
      chk("done_seen", 64'(done), 64'd1);
      chk("done_quiet", 64'({pix_ready, valid, start_ack}), 64'd0);
      done_ack = 1'b1;
      @(negedge clock);
      #1 chk("done_fall", 64'(done), 64'd0);
      @(negedge clock);
      #1 chk("done_stays_low", 64'(done), 64'd0);
      @(negedge clock);
      done_ack = 1'b0;
      @(negedge clock);
      #1 chk("idle_quiet", 64'({done, start_ack, pix_ready}), 64'd0);
   endtask

   initial begin
      pat[0] = 24'hFF0000;
      pat[1] = 24'h00FF00;
      pat[2] = 24'h0000FF;
      pat[3] = 24'hFFFFFF;
      #1 chk("reset_outputs", 64'({start_ack, done, pix_ready, valid, dout}), 64'd0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;

      run_frame(1'b0, 0, 0);   // full rate into buffer 0, partial last word
      done_hs();
      run_frame(1'b1, 1, 0);   // random valid/ready into buffer 1, stray start pulses
      done_hs();
      run_frame(1'b0, 2, 0);   // long backpressure window mid-frame
      done_hs();
      run_frame(1'b1, 1, 6);   // reset pulsed mid-frame
      run_frame(1'b1, 0, 0);   // next frame must restart at the buffer base
      done_hs();
`ifdef PACKER_CHROMAKEY_EN
      run_frame(1'b0, 3, 0);   // transparent lanes and a fully skipped word
      done_hs();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
